// File: rtl/timer_pkg.sv
// Shared definitions for the timer controller: state encoding, mode codes
// and the default terminal count.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MODE_UP0   = 2'b00;  // up from 0
    localparam logic [1:0] MODE_UPSW  = 2'b01;  // up from switch value
    localparam logic [1:0] MODE_DNMAX = 2'b10;  // down from MAX_COUNT
    localparam logic [1:0] MODE_DNSW  = 2'b11;  // down from switch value

    localparam int DEFAULT_MAX_COUNT = 99;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge
// detector producing a single-clock pulse. All flops reset to 1 so a level
// already high when reset releases is not mistaken for a new press.
module sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic pulse
);

    logic meta;
    logic synced;
    logic prev;

    // Synchronise the raw level and remember the previous synchronised value.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta   <= 1'b1;
            synced <= 1'b1;
            prev   <= 1'b1;
        end else begin
            meta   <= din;
            synced <= meta;
            prev   <= synced;
        end
    end

    assign pulse = synced & ~prev;

endmodule

// File: rtl/timer_ctrl.sv
// Start/stop timer controller: loads a start value from mode and BCD switches
// while idle, counts up or down on tick while running, supports pause, and
// latches at the terminal value until acknowledged.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int MAX_COUNT = DEFAULT_MAX_COUNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       startstop,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic [7:0] sw,
    output logic [6:0] count,
    output logic       up_down,
    output logic       running,
    output logic       done,
    output logic       load_err
);

    localparam logic [6:0] MAX_C = 7'(MAX_COUNT);

    state_t     state;
    logic       start;

    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] raw_value;
    logic [6:0] sw_value;
    logic [6:0] reload_count;
    logic       reload_up;
    logic       reload_err;
    logic [6:0] step_value;
    logic       at_terminal;
    logic       step_terminal;

    sync_edge u_sync_edge (
        .clk   (clk),
        .reset (reset),
        .din   (startstop),
        .pulse (start)
    );

    // Sanitise the BCD switches and pick the idle reload value for the mode.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        tens         = (sw[7:4] > 4'd9) ? 4'd0 : sw[7:4];
        units        = (sw[3:0] > 4'd9) ? 4'd0 : sw[3:0];
        raw_value    = {4'd0, tens} * 8'd10 + {4'd0, units};
        sw_value     = (raw_value > {1'b0, MAX_C}) ? MAX_C : raw_value[6:0];
        reload_count = 7'd0;
        reload_up    = 1'b1;
        case (mode)
            MODE_UP0:   begin reload_count = 7'd0;     reload_up = 1'b1; end
            MODE_UPSW:  begin reload_count = sw_value; reload_up = 1'b1; end
            MODE_DNMAX: begin reload_count = MAX_C;    reload_up = 1'b0; end
            MODE_DNSW:  begin reload_count = sw_value; reload_up = 1'b0; end
            default:    begin reload_count = 7'd0;     reload_up = 1'b1; end
        endcase
        // Both switch-sourced modes have mode[0] set.
        reload_err    = mode[0] & ((sw[7:4] > 4'd9) | (sw[3:0] > 4'd9));
        at_terminal   = up_down ? (count == MAX_C) : (count == 7'd0);
        step_value    = up_down ? (count + 7'd1) : (count - 7'd1);
        step_terminal = up_down ? (step_value == MAX_C) : (step_value == 7'd0);
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= 7'd0;
            up_down  <= 1'b1;
            running  <= 1'b0;
            done     <= 1'b0;
            load_err <= 1'b0;
        end else if (clear) begin
            // Abort wins over tick and start; reload as IDLE would.
            state    <= ST_IDLE;
            running  <= 1'b0;
            done     <= 1'b0;
            count    <= reload_count;
            up_down  <= reload_up;
            load_err <= reload_err;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        load_err <= 1'b0;
                        if (at_terminal) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= ST_RUN;
                            running <= 1'b1;
                        end
                    end else begin
                        count    <= reload_count;
                        up_down  <= reload_up;
                        load_err <= reload_err;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        // Pause takes precedence; a coincident tick is dropped.
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end else if (tick) begin
                        count <= step_value;
                        if (step_terminal) begin
                            state   <= ST_DONE;
                            running <= 1'b0;
                            done    <= 1'b1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (start) begin
                        state <= ST_IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    running <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: reset behaviour, all four modes, BCD
// sanitising, pause/resume, terminal hold, clear and asynchronous reset.
module tb_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       startstop;
    logic       clear;
    logic [1:0] mode;
    logic [7:0] sw;
    logic [6:0] count;
    logic       up_down;
    logic       running;
    logic       done;
    logic       load_err;

    int checks   = 0;
    int failures = 0;

    timer_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .startstop (startstop),
        .clear     (clear),
        .mode      (mode),
        .sw        (sw),
        .count     (count),
        .up_down   (up_down),
        .running   (running),
        .done      (done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Hold the button long enough for the synchroniser to emit its pulse,
    // then release and let the synchroniser settle back to low.
    task automatic press();
        startstop = 1'b1;
        repeat (3) @(negedge clk);
        startstop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Press with a tick coincident with the cycle the start pulse is acted on.
    task automatic press_with_tick();
        startstop = 1'b1;
        repeat (2) @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick      = 1'b0;
        startstop = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; startstop = 1'b0; clear = 1'b0;
        mode  = 2'b00; sw = 8'h00;
        #1 reset = 1'b0;
        // Button held through reset release must not start the timer.
        startstop = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_count",    count,    0);
        check("rst_up_down",  up_down,  1);
        check("rst_running",  running,  0);
        check("rst_done",     done,     0);
        check("rst_load_err", load_err, 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        check("held_btn_running", running, 0);
        check("held_btn_done",    done,    0);
        startstop = 1'b0;
        repeat (3) @(negedge clk);

        // Down from MAX_COUNT.
        mode = 2'b10;
        @(negedge clk);
        check("dnmax_count",   count,   99);
        check("dnmax_up_down", up_down, 0);

        // Up from sw already at terminal goes straight to DONE.
        mode = 2'b01; sw = 8'h99;
        @(negedge clk);
        check("upsw99_count", count, 99);
        press();
        check("upsw99_done",    done,    1);
        check("upsw99_running", running, 0);
        press();
        check("upsw99_idle_done", done, 0);

        // Down from sw=00 goes straight to DONE, then back to IDLE.
        mode = 2'b11; sw = 8'h00;
        @(negedge clk);
        check("dn00_count",   count,   0);
        check("dn00_up_down", up_down, 0);
        press();
        check("dn00_done",    done,    1);
        check("dn00_running", running, 0);
        check("dn00_hold",    count,   0);
        press();
        check("dn00_idle_done", done, 0);

        // Invalid tens digit is sanitised to 0 and flagged.
        mode = 2'b01; sw = 8'hA7;
        @(negedge clk);
        check("a7_count",    count,    7);
        check("a7_load_err", load_err, 1);
        press();
        check("a7_running", running, 1);
        repeat (3) do_tick();
        check("a7_after3", count, 10);

        // Clear aborts RUN even with a tick present.
        clear = 1'b1; tick = 1'b1;
        @(negedge clk);
        clear = 1'b0; tick = 1'b0;
        check("clear_running", running, 0);
        mode = 2'b00;
        @(negedge clk);
        check("clear_reload", count, 0);

        // Full up-count 0..99 with terminal hold.
        press();
        check("up_running", running, 1);
        check("up_start",   count,   0);
        for (int i = 1; i <= 99; i++) begin
            do_tick();
            check("up_count", count, 32'(i));
            check("up_done",  done,  (i == 99) ? 32'd1 : 32'd0);
        end
        repeat (3) do_tick();
        check("up_hold_count",   count,   99);
        check("up_hold_done",    done,    1);
        check("up_hold_running", running, 0);
        press();
        check("up_back_idle", done, 0);

        // Down from sw=15 to 0.
        mode = 2'b11; sw = 8'h15;
        @(negedge clk);
        check("dn15_count",   count,   15);
        check("dn15_up_down", up_down, 0);
        press();
        for (int i = 14; i >= 0; i--) begin
            do_tick();
            check("dn15_step", count, 32'(i));
        end
        check("dn15_done",    done,    1);
        check("dn15_up_down_end", up_down, 0);
        // Inputs are frozen outside IDLE.
        sw = 8'h30; mode = 2'b00;
        @(negedge clk);
        check("dn15_frozen_count", count,   0);
        check("dn15_frozen_dir",   up_down, 0);
        press();
        check("dn15_idle_done", done, 0);

        // Pause at 40 with a coincident tick, ticks ignored, resume.
        mode = 2'b00;
        @(negedge clk);
        press();
        repeat (40) do_tick();
        check("p_count40", count, 40);
        press_with_tick();
        check("p_running", running, 0);
        check("p_count",   count,   40);
        repeat (5) do_tick();
        check("p_hold", count, 40);
        press();
        check("p_resumed", running, 1);
        do_tick();
        check("p_count41", count, 41);

        // Asynchronous reset mid-run at 57.
        repeat (16) do_tick();
        check("r_count57", count, 57);
        #2 reset = 1'b0;
        #1;
        check("r_async_count",   count,   0);
        check("r_async_running", running, 0);
        @(negedge clk);
        reset = 1'b1;
        mode  = 2'b10;
        @(negedge clk);
        check("r_reload", count, 99);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
